// File: rtl/ysyx_22051468_fetch_redirect_pkg.sv
// Shared fetch types: FSM state encodings and the sequential PC increment.
package ysyx_22051468_fetch_redirect_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_OUT  = 2'd3
   } fetch_state_e;

   localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/ysyx_22051468_fetch_redirect.sv
// Single-outstanding instruction fetch with branch redirect; in-flight requests
// overtaken by a redirect are tagged stale and their responses dropped.
module ysyx_22051468_fetch_redirect
   import ysyx_22051468_fetch_redirect_pkg::*;
#(
   parameter int unsigned          WIDTH      = 64,
   parameter int unsigned          INST_WIDTH = 32,
   parameter logic [WIDTH-1:0]     RESET_PC   = WIDTH'(64'h8000_0000)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  redirect_i,
   input  logic [WIDTH-1:0]      redirect_pc_i,
   output logic                  imem_req_valid_o,
   input  logic                  imem_req_ready_i,
   output logic [WIDTH-1:0]      imem_req_addr_o,
   input  logic                  imem_rsp_valid_i,
   input  logic [INST_WIDTH-1:0] imem_rsp_data_i,
   output logic                  inst_valid_o,
   input  logic                  inst_ready_i,
   output logic [INST_WIDTH-1:0] inst_o,
   output logic [WIDTH-1:0]      inst_pc_o
);

   fetch_state_e          state_q, state_d;
   logic [WIDTH-1:0]      pc_q, pc_d;
   logic [WIDTH-1:0]      tgt_q, tgt_d;
   logic                  stale_q, stale_d;
   logic [INST_WIDTH-1:0] inst_q, inst_d;
   logic [WIDTH-1:0]      inst_pc_q, inst_pc_d;
   logic [WIDTH-1:0]      tgt_al;

   assign tgt_al = {redirect_pc_i[WIDTH-1:2], 2'b00};

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      tgt_d     = tgt_q;
      stale_d   = stale_q;
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;
      unique case (state_q)
         ST_IDLE: begin
            state_d = ST_REQ;
            if (redirect_i) begin
               tgt_d = tgt_al;
               pc_d  = tgt_al;
            end
         end
         ST_REQ: begin
            // the presented address stays put; the redirect only poisons it
            if (redirect_i) begin
               stale_d = 1'b1;
               tgt_d   = tgt_al;
            end
            if (imem_req_ready_i) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (redirect_i) begin
               stale_d = 1'b1;
               tgt_d   = tgt_al;
            end
            if (imem_rsp_valid_i) begin
               if (stale_q || redirect_i) begin
                  stale_d = 1'b0;
                  pc_d    = redirect_i ? tgt_al : tgt_q;
                  state_d = ST_REQ;
               end else begin
                  inst_d    = imem_rsp_data_i;
                  inst_pc_d = pc_q;
                  pc_d      = pc_q + WIDTH'(PC_INC);
                  state_d   = ST_OUT;
               end
            end
         end
         ST_OUT: begin
            if (redirect_i) begin
               tgt_d   = tgt_al;
               pc_d    = tgt_al;
               state_d = ST_REQ;
            end else if (inst_ready_i) begin
               state_d = ST_REQ;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         pc_q      <= RESET_PC;
         tgt_q     <= '0;
         stale_q   <= 1'b0;
         inst_q    <= '0;
         inst_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         tgt_q     <= tgt_d;
         stale_q   <= stale_d;
         inst_q    <= inst_d;
         inst_pc_q <= inst_pc_d;
      end
   end

   assign imem_req_valid_o = (state_q == ST_REQ);
   assign imem_req_addr_o  = pc_q;
   assign inst_valid_o     = (state_q == ST_OUT);
   assign inst_o           = inst_q;
   assign inst_pc_o        = inst_pc_q;

endmodule

// File: tb/tb_ysyx_22051468_fetch_redirect.sv
// Directed vector table plus randomized traffic checked by a transaction-level
// model built on redirect epochs and an expected-fetch-address pointer.
module tb_ysyx_22051468_fetch_redirect;

   logic        clk;
   logic        rst;
   logic        redirect_i;
   logic [63:0] redirect_pc_i;
   logic        imem_req_valid_o;
   logic        imem_req_ready_i;
   logic [63:0] imem_req_addr_o;
   logic        imem_rsp_valid_i;
   logic [31:0] imem_rsp_data_i;
   logic        inst_valid_o;
   logic        inst_ready_i;
   logic [31:0] inst_o;
   logic [63:0] inst_pc_o;

   int errors = 0;
   int checks = 0;

   ysyx_22051468_fetch_redirect dut (
      .clk              (clk),
      .rst              (rst),
      .redirect_i       (redirect_i),
      .redirect_pc_i    (redirect_pc_i),
      .imem_req_valid_o (imem_req_valid_o),
      .imem_req_ready_i (imem_req_ready_i),
      .imem_req_addr_o  (imem_req_addr_o),
      .imem_rsp_valid_i (imem_rsp_valid_i),
      .imem_rsp_data_i  (imem_rsp_data_i),
      .inst_valid_o     (inst_valid_o),
      .inst_ready_i     (inst_ready_i),
      .inst_o           (inst_o),
      .inst_pc_o        (inst_pc_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        redir;
      logic [63:0] tgt;
      logic        rdy;
      logic        rsp;
      logic [31:0] data;
      logic        irdy;
      logic        e_rv;
      logic [63:0] e_addr;
      logic        e_iv;
      logic [31:0] e_inst;
      logic [63:0] e_pc;
   } vec_t;

   vec_t tbl[27];

   function automatic vec_t mk(logic redir, logic [63:0] tgt, logic rdy, logic rsp,
                               logic [31:0] data, logic irdy, logic e_rv, logic [63:0] e_addr,
                               logic e_iv, logic [31:0] e_inst, logic [63:0] e_pc);
      vec_t v;
      v.redir = redir; v.tgt = tgt; v.rdy = rdy; v.rsp = rsp; v.data = data; v.irdy = irdy;
      v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_inst = e_inst; v.e_pc = e_pc;
      return v;
   endfunction

   function automatic logic [31:0] mem_data(logic [63:0] a);
      return a[31:0] ^ 32'h5A5A_1234 ^ {a[63:48], 16'h0};
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      redirect_i       = 1'b0;
      redirect_pc_i    = '0;
      imem_req_ready_i = 1'b0;
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = '0;
      inst_ready_i     = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // random-phase model state
   int          epoch, pres_tag, out_tag, cnt, delivered;
   logic [63:0] exp_addr, pres_addr, out_addr, h_pc;
   logic [31:0] h_inst;
   bit          presenting, m_out, m_hold, prev_redir, hs;

   initial begin
      clear_inputs();
      rst = 1'b1;
      #2;
      chk("reset_req_valid", imem_req_valid_o, 0);
      chk("reset_inst_valid", inst_valid_o, 0);
      chk("reset_inst", inst_o, 0);
      chk("reset_inst_pc", inst_pc_o, 0);
      step();
      step();
      rst = 1'b0;
      chk("idle_req_valid", imem_req_valid_o, 0);

      // {redir, tgt, rdy, rsp, data, irdy} -> {req_valid, req_addr, inst_valid, inst, inst_pc}
      tbl[0]  = mk(0, 64'h0, 0, 0, 32'h0, 0,             1, 64'h8000_0000, 0, 32'h0, 64'h0);
      tbl[1]  = mk(0, 64'h0, 1, 0, 32'h0, 0,             0, 64'h0,         0, 32'h0, 64'h0);
      tbl[2]  = mk(0, 64'h0, 0, 1, 32'h1111_1111, 0,     0, 64'h0,         1, 32'h1111_1111, 64'h8000_0000);
      tbl[3]  = mk(0, 64'h0, 0, 0, 32'h0, 0,             0, 64'h0,         1, 32'h1111_1111, 64'h8000_0000);
      tbl[4]  = mk(0, 64'h0, 1, 0, 32'hFFFF_FFFF, 0,     0, 64'h0,         1, 32'h1111_1111, 64'h8000_0000);
      tbl[5]  = mk(0, 64'h0, 0, 0, 32'h0, 0,             0, 64'h0,         1, 32'h1111_1111, 64'h8000_0000);
      tbl[6]  = mk(0, 64'h0, 0, 0, 32'h0, 1,             1, 64'h8000_0004, 0, 32'h0, 64'h0);
      tbl[7]  = mk(0, 64'h0, 1, 0, 32'h0, 0,             0, 64'h0,         0, 32'h0, 64'h0);
      tbl[8]  = mk(1, 64'h8000_0103, 0, 0, 32'h0, 0,     0, 64'h0,         0, 32'h0, 64'h0);
      tbl[9]  = mk(0, 64'h0, 0, 1, 32'h2222_2222, 0,     1, 64'h8000_0100, 0, 32'h0, 64'h0);
      tbl[10] = mk(1, 64'h8000_0200, 1, 0, 32'h0, 0,     0, 64'h0,         0, 32'h0, 64'h0);
      tbl[11] = mk(0, 64'h0, 0, 1, 32'h3333_3333, 0,     1, 64'h8000_0200, 0, 32'h0, 64'h0);
      tbl[12] = mk(0, 64'h0, 1, 0, 32'h0, 0,             0, 64'h0,         0, 32'h0, 64'h0);
      tbl[13] = mk(0, 64'h0, 0, 1, 32'h4444_4444, 0,     0, 64'h0,         1, 32'h4444_4444, 64'h8000_0200);
      tbl[14] = mk(1, 64'h8000_0ABE, 0, 0, 32'h0, 1,     1, 64'h8000_0ABC, 0, 32'h0, 64'h0);
      tbl[15] = mk(1, 64'h8000_0300, 0, 0, 32'h0, 0,     1, 64'h8000_0ABC, 0, 32'h0, 64'h0);
      tbl[16] = mk(1, 64'h8000_0401, 1, 0, 32'h0, 0,     0, 64'h0,         0, 32'h0, 64'h0);
      tbl[17] = mk(0, 64'h0, 0, 1, 32'h5555_5555, 0,     1, 64'h8000_0400, 0, 32'h0, 64'h0);
      tbl[18] = mk(0, 64'h0, 1, 0, 32'h0, 0,             0, 64'h0,         0, 32'h0, 64'h0);
      tbl[19] = mk(0, 64'h0, 0, 1, 32'h6666_6666, 0,     0, 64'h0,         1, 32'h6666_6666, 64'h8000_0400);
      tbl[20] = mk(0, 64'h0, 0, 0, 32'h0, 1,             1, 64'h8000_0404, 0, 32'h0, 64'h0);
      tbl[21] = mk(1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 32'h0, 0, 1, 64'h8000_0404, 0, 32'h0, 64'h0);
      tbl[22] = mk(0, 64'h0, 1, 0, 32'h0, 0,             0, 64'h0,         0, 32'h0, 64'h0);
      tbl[23] = mk(0, 64'h0, 0, 1, 32'h6A6A_6A6A, 0,     1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 32'h0, 64'h0);
      tbl[24] = mk(0, 64'h0, 1, 0, 32'h0, 0,             0, 64'h0,         0, 32'h0, 64'h0);
      tbl[25] = mk(0, 64'h0, 0, 1, 32'h7777_7777, 0,     0, 64'h0,         1, 32'h7777_7777, 64'hFFFF_FFFF_FFFF_FFFC);
      tbl[26] = mk(0, 64'h0, 0, 0, 32'h0, 1,             1, 64'h0,         0, 32'h0, 64'h0);

      for (int i = 0; i < 27; i++) begin
         redirect_i       = tbl[i].redir;
         redirect_pc_i    = tbl[i].tgt;
         imem_req_ready_i = tbl[i].rdy;
         imem_rsp_valid_i = tbl[i].rsp;
         imem_rsp_data_i  = tbl[i].data;
         inst_ready_i     = tbl[i].irdy;
         step();
         clear_inputs();
         chk($sformatf("vec%0d_req_valid", i), imem_req_valid_o, tbl[i].e_rv);
         if (tbl[i].e_rv) chk($sformatf("vec%0d_req_addr", i), imem_req_addr_o, tbl[i].e_addr);
         chk($sformatf("vec%0d_inst_valid", i), inst_valid_o, tbl[i].e_iv);
         if (tbl[i].e_iv) begin
            chk($sformatf("vec%0d_inst", i), inst_o, tbl[i].e_inst);
            chk($sformatf("vec%0d_inst_pc", i), inst_pc_o, tbl[i].e_pc);
         end
      end

      // reset pulse while a response is outstanding; the late response must vanish
      imem_req_ready_i = 1'b1;
      step();
      imem_req_ready_i = 1'b0;
      chk("rstw_in_wait", imem_req_valid_o, 0);
      rst = 1'b1;
      #1;
      chk("rstw_async_inst_valid", inst_valid_o, 0);
      chk("rstw_async_inst_pc", inst_pc_o, 0);
      chk("rstw_async_inst", inst_o, 0);
      step();
      rst = 1'b0;
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = 32'hDEAD_BEEF;
      step();
      chk("rstw_req_valid", imem_req_valid_o, 1);
      chk("rstw_req_addr", imem_req_addr_o, 64'h8000_0000);
      chk("rstw_inst_valid", inst_valid_o, 0);
      step();
      imem_rsp_valid_i = 1'b0;
      chk("rstw_late_inst_valid", inst_valid_o, 0);
      chk("rstw_req_addr_hold", imem_req_addr_o, 64'h8000_0000);
      imem_req_ready_i = 1'b1;
      step();
      imem_req_ready_i = 1'b0;
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = 32'h0BAD_F00D;
      step();
      clear_inputs();
      chk("rstw_fresh_inst_valid", inst_valid_o, 1);
      chk("rstw_fresh_inst", inst_o, 32'h0BAD_F00D);
      chk("rstw_fresh_inst_pc", inst_pc_o, 64'h8000_0000);

      // randomized traffic against the epoch model
      rst = 1'b1;
      step();
      rst = 1'b0;
      epoch = 0; delivered = 0; cnt = 0; pres_tag = 0; out_tag = 0;
      exp_addr = 64'h8000_0000; pres_addr = '0; out_addr = '0; h_pc = '0; h_inst = '0;
      presenting = 0; m_out = 0; m_hold = 0; prev_redir = 0;
      for (int c = 0; c < 3000; c++) begin
         chk("rnd_inst_valid", inst_valid_o, m_hold);
         if (m_hold) begin
            chk("rnd_inst", inst_o, h_inst);
            chk("rnd_inst_pc", inst_pc_o, h_pc);
         end
         chk("rnd_req_while_busy", imem_req_valid_o & (m_out | m_hold), 0);
         if (imem_req_valid_o) begin
            if (!presenting) begin
               pres_addr  = exp_addr;
               pres_tag   = epoch;
               presenting = 1;
            end
            chk("rnd_req_addr", imem_req_addr_o, pres_addr);
         end

         imem_req_ready_i = 1'($urandom_range(0, 1));
         inst_ready_i     = ($urandom_range(0, 9) < 6);
         imem_rsp_valid_i = m_out && (cnt == 0);
         imem_rsp_data_i  = imem_rsp_valid_i ? mem_data(out_addr) : $urandom;
         redirect_i       = !prev_redir && ($urandom_range(0, 9) == 0);
         redirect_pc_i    = (c % 7 == 3) ? {$urandom, $urandom}
                                         : (64'h8000_0000 | 64'($urandom_range(0, 65535)));

         hs = imem_req_valid_o && imem_req_ready_i;
         if (inst_valid_o && inst_ready_i) m_hold = 0;
         if (redirect_i) begin
            epoch++;
            exp_addr = redirect_pc_i & ~64'h3;
            m_hold   = 0;
         end
         if (m_out) begin
            if (imem_rsp_valid_i) begin
               m_out = 0;
               if (out_tag == epoch) begin
                  m_hold    = 1;
                  h_inst    = imem_rsp_data_i;
                  h_pc      = out_addr;
                  exp_addr  = out_addr + 64'd4;
                  delivered++;
               end
            end else begin
               cnt--;
            end
         end
         if (hs) begin
            presenting = 0;
            m_out      = 1;
            out_addr   = pres_addr;
            out_tag    = pres_tag;
            cnt        = $urandom_range(0, 3);
         end
         prev_redir = redirect_i;
         step();
      end
      clear_inputs();
      chk("rnd_delivered_enough", 64'(delivered > 50), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
